// File: rtl/vlsu_cam_alloc.sv
// rtl/vlsu_cam_alloc.sv - circular-age slot allocator driving the VLSU CAM write/clear/head/enable ports
module vlsu_cam_alloc #(
    parameter  int WIDTH   = 50,
    parameter  int DEPTH   = 32,
    parameter  int READ    = 3,
    localparam int ADDRESS = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid_i,
    input  logic [WIDTH-1:0]         alloc_data_i,
    output logic                     alloc_ready_o,
    output logic [ADDRESS-1:0]       alloc_idx_o,
    input  logic                     retire_i,
    input  logic                     flush_i,
    output logic                     cam_write_o,
    output logic [ADDRESS-1:0]       cam_write_addr_o,
    output logic [WIDTH-1:0]         cam_write_data_o,
    output logic                     cam_clear_o,
    output logic [ADDRESS-1:0]       cam_clear_addr_o,
    output logic [ADDRESS-1:0]       cam_head_o,
    output logic [READ*DEPTH-1:0]    cam_enable_o,
    output logic [ADDRESS:0]         count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    logic [ADDRESS-1:0] tail_q;
    logic [ADDRESS-1:0] head_q;
    logic [ADDRESS:0]   count_q;
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   valid_next;

    logic               wr_strobe_q;
    logic [ADDRESS-1:0] wr_addr_q;
    logic [WIDTH-1:0]   wr_data_q;
    logic               clr_strobe_q;
    logic [ADDRESS-1:0] clr_addr_q;

    logic handshake;
    logic do_retire;

    assign full_o        = (count_q == (ADDRESS+1)'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign alloc_ready_o = !full_o && !flush_i && !rst;
    assign handshake     = alloc_valid_i && alloc_ready_o;
    assign do_retire     = retire_i && !empty_o && !flush_i;

    assign alloc_idx_o      = tail_q;
    assign cam_head_o       = head_q;
    assign count_o          = count_q;
    assign cam_write_o      = wr_strobe_q;
    assign cam_write_addr_o = wr_addr_q;
    assign cam_write_data_o = wr_data_q;
    assign cam_clear_o      = clr_strobe_q;
    assign cam_clear_addr_o = clr_addr_q;
    assign cam_enable_o     = {READ{valid_q}};

    // A slot becomes searchable only once its write has landed; a same-edge retire of that slot wins.
    always_comb begin
        valid_next = valid_q;
        if (wr_strobe_q) begin
            valid_next[wr_addr_q] = 1'b1;
        end
        if (do_retire) begin
            valid_next[head_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            tail_q       <= '0;
            head_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            wr_strobe_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            clr_strobe_q <= 1'b0;
            clr_addr_q   <= '0;
        end else begin
            wr_strobe_q  <= handshake;
            clr_strobe_q <= do_retire;
            valid_q      <= valid_next;

            if (handshake) begin
                wr_addr_q <= tail_q;
                wr_data_q <= alloc_data_i;
                tail_q    <= tail_q + ADDRESS'(1);
            end

            if (do_retire) begin
                clr_addr_q <= head_q;
                head_q     <= head_q + ADDRESS'(1);
            end

            case ({handshake, do_retire})
                2'b10:   count_q <= count_q + (ADDRESS+1)'(1);
                2'b01:   count_q <= count_q - (ADDRESS+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
